// File: rtl/pc_predict_unit_pkg.sv
// pc_predict_unit_pkg: shared definitions for the pre-fetch PC generator.
//   - RESET_PC_DEFAULT : first fetch address after reset
//   - BTB entry field widths
//   - pf_state_e       : pre-fetch FSM states
//   - ctr_inc/ctr_dec  : 2-bit saturating counter helpers (used when the
//                        BTB_BHT_EN macro is defined)
package pc_predict_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
   localparam int unsigned PC_W             = 32;
   localparam int unsigned TARGET_W         = 30;   // target[31:2]; low bits are always 0
   localparam int unsigned CTR_W            = 2;
   localparam logic [1:0]  CTR_ALLOC        = 2'b10;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } pf_state_e;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/pc_predict_unit_btb_table.sv
// btb_table: direct-mapped branch target buffer.
//   clk, reset           : clock, synchronous active-high reset (clears valids)
//   rd_word, rd_hit,
//   rd_target            : combinational lookup on PC[31:2]; hit and target[31:2]
//   wr_valid, wr_word,
//   wr_taken, wr_target  : one training write per cycle, applied at the clock edge
// Optional: BTB_BHT_EN adds a 2-bit saturating counter per entry; a hit then
// predicts taken only when the counter's upper bit is set.
module btb_table
   import pc_predict_unit_pkg::*;
#(
   parameter int unsigned ENTRIES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] rd_word,
   output logic        rd_hit,
   output logic [29:0] rd_target,
   input  logic        wr_valid,
   input  logic [29:0] wr_word,
   input  logic        wr_taken,
   input  logic [29:0] wr_target
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = TARGET_W - IDX_W;

   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [TAG_W-1:0]    tag_d    [ENTRIES];
   logic [29:0]         target_q [ENTRIES];
   logic [29:0]         target_d [ENTRIES];
`ifdef BTB_BHT_EN
   logic [CTR_W-1:0]    ctr_q    [ENTRIES];
   logic [CTR_W-1:0]    ctr_d    [ENTRIES];
`endif

   logic [IDX_W-1:0]    rd_idx, wr_idx;
   logic [TAG_W-1:0]    rd_tag, wr_tag;
   logic                wr_match;

   always_comb begin
      rd_idx = rd_word[IDX_W-1:0];
      rd_tag = rd_word[TARGET_W-1 -: TAG_W];
      wr_idx = wr_word[IDX_W-1:0];
      wr_tag = wr_word[TARGET_W-1 -: TAG_W];
   end

   // Read port sees only registered contents: no bypass from a same-cycle write.
   always_comb begin
      rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
`ifdef BTB_BHT_EN
      rd_hit    = rd_hit && ctr_q[rd_idx][1];
`endif
      rd_target = target_q[rd_idx];
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
`ifdef BTB_BHT_EN
      ctr_d    = ctr_q;
`endif
      wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
      if (wr_valid) begin
         if (wr_taken) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
`ifdef BTB_BHT_EN
            ctr_d[wr_idx]    = wr_match ? ctr_inc(ctr_q[wr_idx]) : CTR_ALLOC;
`endif
         end else if (wr_match) begin
`ifdef BTB_BHT_EN
            ctr_d[wr_idx]    = ctr_dec(ctr_q[wr_idx]);
`else
            valid_d[wr_idx]  = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
`ifdef BTB_BHT_EN
         ctr_q    <= ctr_d;
`endif
      end
   end

endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: pre-fetch stage PC generator with BTB-based next-PC prediction.
//   clk, reset         : clock, synchronous active-high reset
//   if_allowin         : IF stage accepts a PC this cycle
//   inst_sram_en/addr  : instruction fetch request / address (= fetch_pc)
//   pf_to_if_valid     : fetch_pc/pred_pc valid toward IF
//   fetch_pc, pred_pc  : PC being fetched and its predicted successor
//   br_taken_cancel,
//   br_next_pc         : resolved misprediction and corrected PC
//   br_upd_*           : BTB training from a resolved branch
// Optional: BTB_BHT_EN enables 2-bit direction counters in the BTB.
module pc_predict_unit
   import pc_predict_unit_pkg::*;
#(
   parameter int unsigned BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_allowin,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr,
   output logic        pf_to_if_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] pred_pc,
   input  logic        br_taken_cancel,
   input  logic [31:0] br_next_pc,
   input  logic        br_upd_valid,
   input  logic [31:0] br_upd_pc,
   input  logic        br_upd_taken,
   input  logic [31:0] br_upd_target
);

   pf_state_e   state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        btb_hit;
   logic [29:0] btb_target;
   logic        fire;
   logic [3:0]  unused_low_bits;

   // Word-aligned BTB: the byte-offset bits of the training inputs are ignored.
   assign unused_low_bits = {br_upd_pc[1:0], br_upd_target[1:0]};

   btb_table #(
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk       (clk),
      .reset     (reset),
      .rd_word   (fetch_pc_q[31:2]),
      .rd_hit    (btb_hit),
      .rd_target (btb_target),
      .wr_valid  (br_upd_valid),
      .wr_word   (br_upd_pc[31:2]),
      .wr_taken  (br_upd_taken),
      .wr_target (br_upd_target[31:2])
   );

   always_comb begin
      fetch_pc       = fetch_pc_q;
      inst_sram_addr = fetch_pc_q;
      pred_pc        = btb_hit ? {btb_target, 2'b00} : fetch_pc_q + 32'd4;
      // Gated by reset so nothing is requested during the reset cycle itself.
      pf_to_if_valid = !reset && (state_q == RUN);
      fire           = pf_to_if_valid && if_allowin;
      inst_sram_en   = fire;

      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (br_taken_cancel) begin
         // Cancel wins over a fire in the same cycle: the predicted PC is dropped.
         state_d    = REDIRECT;
         fetch_pc_d = br_next_pc;
      end else begin
         unique case (state_q)
            BOOT:     state_d = RUN;
            RUN:      if (fire) fetch_pc_d = pred_pc;
            REDIRECT: state_d = RUN;
            default:  state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: randomized + directed bench for pc_predict_unit.
// The stimulus process drives one cycle at a time, queues the expected
// per-cycle outputs and the expected fetch requests from a behavioural
// model; a negedge monitor pops and compares.
module tb_pc_predict_unit;

   localparam int unsigned N      = 16;
   localparam int unsigned IB     = $clog2(N);
   localparam logic [31:0] RST_PC = 32'h1c000000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_allowin = 1'b0;
   logic        br_taken_cancel = 1'b0;
   logic [31:0] br_next_pc = '0;
   logic        br_upd_valid = 1'b0;
   logic [31:0] br_upd_pc = '0;
   logic        br_upd_taken = 1'b0;
   logic [31:0] br_upd_target = '0;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic        pf_to_if_valid;
   logic [31:0] fetch_pc;
   logic [31:0] pred_pc;

   pc_predict_unit #(
      .BTB_ENTRIES (N),
      .RESET_PC    (RST_PC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .if_allowin      (if_allowin),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .pf_to_if_valid  (pf_to_if_valid),
      .fetch_pc        (fetch_pc),
      .pred_pc         (pred_pc),
      .br_taken_cancel (br_taken_cancel),
      .br_next_pc      (br_next_pc),
      .br_upd_valid    (br_upd_valid),
      .br_upd_pc       (br_upd_pc),
      .br_upd_taken    (br_upd_taken),
      .br_upd_target   (br_upd_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      bit          v;
      logic [31:0] pc;
      logic [31:0] pred;
   } exp_t;

   exp_t        exp_q[$];    // every cycle
   exp_t        fire_q[$];   // only cycles where a fetch request is expected
   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned failures = 0;

   // Behavioural model: a direct-mapped table plus "is this a bubble cycle".
   bit          m_val [N];
   int unsigned m_tag [N];
   logic [31:0] m_tgt [N];
   int          m_ctr [N];
   logic [31:0] m_pc = RST_PC;
   bit          m_bubble = 1'b1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, expv);
      end
   endfunction

   function automatic logic [31:0] model_pred(input logic [31:0] pc);
      int unsigned i;
      int unsigned t;
      bit          hit;
      i   = (pc >> 2) % N;
      t   = pc >> (2 + IB);
      hit = m_val[i] && (m_tag[i] == t);
`ifdef BTB_BHT_EN
      hit = hit && (m_ctr[i] >= 2);
`endif
      return hit ? m_tgt[i] : pc + 32'd4;
   endfunction

   function automatic void model_train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
      int unsigned i;
      int unsigned t;
      bit          match;
      i     = (pc >> 2) % N;
      t     = pc >> (2 + IB);
      match = m_val[i] && (m_tag[i] == t);
      if (taken) begin
`ifdef BTB_BHT_EN
         m_ctr[i] = match ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
`endif
         m_val[i] = 1'b1;
         m_tag[i] = t;
         m_tgt[i] = tgt & 32'hffff_fffc;
      end else if (match) begin
`ifdef BTB_BHT_EN
         m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
`else
         m_val[i] = 1'b0;
`endif
      end
   endfunction

   task automatic step(input bit rst, input bit ai, input bit cx, input logic [31:0] npc,
                       input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
      exp_t e;
      reset           = rst;
      if_allowin      = ai;
      br_taken_cancel = cx;
      br_next_pc      = npc;
      br_upd_valid    = uv;
      br_upd_pc       = upc;
      br_upd_taken    = ut;
      br_upd_target   = utg;
      e.cyc  = cyc;
      e.v    = !rst && !m_bubble;
      e.pc   = m_pc;
      e.pred = model_pred(m_pc);
      exp_q.push_back(e);
      if (e.v && ai) fire_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         for (int i = 0; i < N; i++) m_val[i] = 1'b0;
         m_pc     = RST_PC;
         m_bubble = 1'b1;
      end else begin
         if (uv) model_train(upc, ut, utg);
         if (cx) begin
            m_pc     = npc;
            m_bubble = 1'b1;
         end else begin
            if (e.v && ai) m_pc = e.pred;
            m_bubble = 1'b0;
         end
      end
   endtask

   task automatic run(input bit ai);
      step(1'b0, ai, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic cancel(input logic [31:0] npc, input bit ai);
      step(1'b0, ai, 1'b1, npc, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt, input bit ai);
      step(1'b0, ai, 1'b0, '0, 1'b1, pc, taken, tgt);
   endtask

   function automatic logic [31:0] region_pc();
      return 32'h1c000000 + ($urandom_range(0, 63) << 2);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      exp_t f;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pf_to_if_valid", {31'd0, pf_to_if_valid}, {31'd0, e.v});
         if (e.v) begin
            chk("fetch_pc", fetch_pc, e.pc);
            chk("pred_pc", pred_pc, e.pred);
         end
         if (inst_sram_en) begin
            if (fire_q.size() == 0) begin
               chk("unexpected_fetch_request", 32'd1, 32'd0);
            end else begin
               f = fire_q.pop_front();
               chk("fire_cycle", cyc, f.cyc);
               chk("inst_sram_addr", inst_sram_addr, f.pc);
               chk("fire_pred_pc", pred_pc, f.pred);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] npc;
      int unsigned r;
      @(posedge clk);
      #1;
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);

      // Boot bubble, sequential fetch, stall at 1c000008, resume.
      repeat (3) run(1'b1);
      repeat (3) run(1'b0);
      run(1'b1);

      // Train 1c000010 -> 1c000100 while firing 1c00000c, then follow it.
      train(32'h1c000010, 1'b1, 32'h1c000100, 1'b1);
      repeat (3) run(1'b1);

      // Redirect during a fire.
      cancel(32'h1c000200, 1'b1);
      repeat (2) run(1'b1);

      // Not-taken training, then look at 1c000010.
      train(32'h1c000010, 1'b0, 32'h0, 1'b1);
      cancel(32'h1c000010, 1'b1);
      run(1'b1);
      run(1'b0);
      train(32'h1c000010, 1'b1, 32'h1c000100, 1'b0);
      train(32'h1c000010, 1'b1, 32'h1c000100, 1'b0);
      run(1'b0);

      // Alias: same index, different tag.
      cancel(32'h1c000050, 1'b1);
      run(1'b1);
      run(1'b0);

      // Same-cycle update and lookup at one index sees the old entry.
      cancel(32'h1c000010, 1'b0);
      run(1'b0);
      train(32'h1c000010, 1'b1, 32'h1c000300, 1'b0);
      run(1'b0);
      run(1'b1);

      // Address wrap at the top of the space.
      cancel(32'hfffffffc, 1'b1);
      repeat (3) run(1'b1);

      // Reset mid-operation discards a pending redirect and update.
      step(1'b1, 1'b1, 1'b1, 32'h1c000400, 1'b1, 32'h1c000000, 1'b1, 32'h1c000500);
      repeat (3) run(1'b1);

      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 19);
         if (r == 0)      npc = 32'hfffffffc;
         else if (r == 1) npc = region_pc() + 32'd1;
         else             npc = region_pc();
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < 70),
              ($urandom_range(0, 99) < 8),
              npc,
              ($urandom_range(0, 99) < 35),
              region_pc(),
              ($urandom_range(0, 99) < 60),
              region_pc());
      end
      run(1'b0);

      chk("pending_fetch_requests", fire_q.size(), 32'd0);
      chk("pending_cycle_records", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
Pre-fetch stage PC generator and predictor that produces the `pred_PC` later checked by the branch resolution logic. It holds the fetch PC and issues instruction-SRAM requests. It predicts the next PC from a direct-mapped BTB, trained by resolved branches. On a resolved misprediction it redirects to the corrected PC.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, 4..64.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_allowin  in  1  IF stage can accept a PC this cycle.
- inst_sram_en  out  1  instruction fetch request.
- inst_sram_addr  out  32  fetch address, equal to fetch_pc.
- pf_to_if_valid  out  1  fetch_pc/pred_pc valid toward IF.
- fetch_pc  out  32  PC being fetched.
- pred_pc  out  32  predicted next PC for fetch_pc; carried down the pipe.
- br_taken_cancel  in  1  resolved misprediction; redirect required.
- br_next_pc  in  32  correct next PC, valid with br_taken_cancel.
- br_upd_valid  in  1  a branch/jump resolved this cycle.
- br_upd_pc  in  32  PC of the resolved branch.
- br_upd_taken  in  1  resolved direction.
- br_upd_target  in  32  resolved taken target.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset:
  - fetch_pc=RESET_PC.
  - State=BOOT.
  - All BTB valid bits cleared.
  - pf_to_if_valid=0 and inst_sram_en=0 during the reset cycle.
- Index and tag:
  - idx=pc[2+:log2(BTB_ENTRIES)].
  - tag=pc[31:2+log2(BTB_ENTRIES)].
  - Entry contents: valid, tag, target[31:2]; target[1:0] is stored as 0.
- Lookup is combinational on fetch_pc.
  - hit = valid & (tag match).
  - pred_pc = hit ? {target,2'b00} : fetch_pc+32'd4 (mod 2^32; wraps 0xFFFFFFFC->0).
- State machine:
  - BOOT: pf_to_if_valid=0. Next cycle goes to RUN. Guarantees a clean first request.
  - RUN: pf_to_if_valid=1 and inst_sram_en=if_allowin.
    - fire = pf_to_if_valid & if_allowin.
    - On fire: fetch_pc<=pred_pc.
    - Without fire: fetch_pc holds, as do all outputs.
  - REDIRECT: entered on br_taken_cancel from any non-reset state.
    - fetch_pc<=br_next_pc in the same edge.
    - pf_to_if_valid=0 for exactly that one cycle, so no wrong-path request issues.
    - Next cycle goes to RUN.
- Priority: reset > br_taken_cancel > fire > hold.
  - Cancel during a fire cycle discards the fired sequential/predicted PC.
- BTB update happens on the edge after a cycle with br_upd_valid=1.
  - taken: write entry[idx(br_upd_pc)] with valid=1, tag, target.
  - not taken & entry tag matches: valid<=0.
  - not taken & no match: no change.
- Update and lookup to the same index in the same cycle: lookup sees the pre-update value (no bypass).
- br_next_pc misalignment is not checked; the PC is passed through and exceptions are handled downstream.
- Reset asserted mid-operation discards any pending redirect or update.

Optional Feature:
- Macro: BTB_BHT_EN.
- When defined:
  - Each entry adds a 2-bit saturating counter.
  - Taken prediction = hit & ctr[1].
  - Allocation on a taken miss sets ctr=2'b10.
  - A taken hit increments the counter, saturating at 3.
  - A not-taken hit decrements it, saturating at 0; the entry stays valid.
- When undefined: no counters; predict taken on hit; a not-taken hit invalidates the entry as above.

Decomposition:
- Shared package/header (myCPU.h):
  - RESET_PC default.
  - BTB entry field widths.
  - STATE encodings: BOOT=2'd0, RUN=2'd1, REDIRECT=2'd2.
- One sub-module: btb_table.
  - Storage, combinational read port, single write port.
  - BHT counters, under BTB_BHT_EN.
- pc_predict_unit holds the FSM, PC register and mux.

Test Plan:
1. Reset, then if_allowin=1 constantly -> cycle 1 pf_to_if_valid=0; then fetch_pc 1c000000, 1c000004, 1c000008; pred_pc = fetch_pc+4.
2. if_allowin=0 for 3 cycles at fetch_pc=1c000008 -> fetch_pc and pred_pc hold and inst_sram_en=0; resume -> 1c00000c.
3. br_upd_valid with pc=1c000010, taken, target=1c000100; later fetch_pc=1c000010 -> pred_pc=1c000100 and next fetch_pc=1c000100.
4. br_taken_cancel with br_next_pc=1c000200 while firing -> one cycle pf_to_if_valid=0, then fetch_pc=1c000200.
5. Not-taken update at 1c000010 (BHT off) -> entry invalidated, pred_pc=1c000014. With BTB_BHT_EN: ctr 2->1, pred_pc=1c000014; two taken updates -> ctr 3 and predicts 1c000100.
6. Aliasing: entry for 1c000010 present, fetch 1c000050 (same idx at 16 entries, different tag) -> miss, pred_pc=1c000054. Simultaneous update/lookup at the same idx -> lookup returns the old value.
